im_loader: RTL and testbench

// Boot-time program loader for the shared 4-port instruction memory. Takes a byte stream
// (UART receiver side), packs bytes into 16-bit instruction words and drives the memory's

---
 rtl/im_loader_pkg.sv | 17 +
 rtl/im_loader.sv | 118 +++++++++++
 tb/tb_im_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM state encoding and byte-stream header layout.
package im_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_W_HI,
        ST_W_LO,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 2 * BYTE_W;

endpackage

// File: rtl/im_loader.sv
// Boot loader: packs a UART byte stream (count header, then MSB-first words) into
// instruction-memory writes, holding the cores until the whole program is in.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for count high byte
// ST_CNT_LO | waiting for count low byte; validates word count
// ST_W_HI   | waiting for high byte of next word
// ST_W_LO   | waiting for low byte; its arrival issues the memory write
// ST_DONE   | program loaded, cores released (start pulse on first cycle)
// ST_ERR    | header invalid, cores kept stalled, bytes ignored
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 101,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    input  logic                reload,
    output logic                im_write_en,
    output logic [DATA_W-1:0]   im_input_data,
    output logic [ADDR_W-1:0]   im_addr,
    output logic                cores_hold,
    output logic                core_start,
    output logic                load_done,
    output logic                load_err,
    output logic [CNT_W-1:0]    words_loaded
);

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(DEPTH - BASE_ADDR);

    state_t              state;
    state_t              state_next;
    logic [BYTE_W-1:0]   cnt_hi;
    logic [BYTE_W-1:0]   word_hi;
    logic [CNT_W-1:0]    word_total;
    logic [CNT_W-1:0]    index;
    logic [CNT_W-1:0]    cnt_rx;
    logic                last_word;

    assign cnt_rx       = {cnt_hi, rx_data};
    assign last_word    = (index + CNT_W'(1)) == word_total;
    assign words_loaded = index;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (reload) begin
            state_next = ST_IDLE;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE:   state_next = ST_CNT_LO;
                ST_CNT_LO: state_next = (cnt_rx == '0 || cnt_rx > MAX_WORDS) ? ST_ERR : ST_W_HI;
                ST_W_HI:   state_next = ST_W_LO;
                ST_W_LO:   state_next = last_word ? ST_DONE : ST_W_HI;
                default:   state_next = state;
            endcase
        end
    end

    // Status outputs lag the state by one cycle so the release follows the last write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_hi        <= '0;
            word_hi       <= '0;
            word_total    <= '0;
            index         <= '0;
            im_write_en   <= 1'b0;
            im_input_data <= '0;
            im_addr       <= '0;
            cores_hold    <= 1'b1;
            core_start    <= 1'b0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            im_write_en <= 1'b0;
            if (reload) begin
                index      <= '0;
                cores_hold <= 1'b1;
                core_start <= 1'b0;
                load_done  <= 1'b0;
                load_err   <= 1'b0;
            end else begin
                load_done  <= (state == ST_DONE);
                core_start <= (state == ST_DONE) && !load_done;
                cores_hold <= (state != ST_DONE);
                load_err   <= (state == ST_ERR);
                if (rx_valid) begin
                    case (state)
                        ST_IDLE:   cnt_hi     <= rx_data;
                        ST_CNT_LO: word_total <= cnt_rx;
                        ST_W_HI:   word_hi    <= rx_data;
                        ST_W_LO: begin
                            im_write_en   <= 1'b1;
                            im_input_data <= DATA_W'({word_hi, rx_data});
                            im_addr       <= ADDR_W'(BASE_ADDR) + ADDR_W'(index);
                            index         <= index + CNT_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader: normal load, gapped stream,
// header errors, full-depth load, mid-load reload and post-done traffic.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        reload = 1'b0;
    logic        im_write_en;
    logic [15:0] im_input_data;
    logic [15:0] im_addr;
    logic        cores_hold;
    logic        core_start;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_data_q[$];
    logic [15:0] wr_addr_q[$];
    int          wr_cyc_q[$];
    int          cyc = 0;
    int          starts = 0;

    im_loader #(.DATA_W(16), .ADDR_W(16), .DEPTH(101), .BASE_ADDR(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .reload        (reload),
        .im_write_en   (im_write_en),
        .im_input_data (im_input_data),
        .im_addr       (im_addr),
        .cores_hold    (cores_hold),
        .core_start    (core_start),
        .load_done     (load_done),
        .load_err      (load_err),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (im_write_en === 1'b1) begin
            wr_data_q.push_back(im_input_data);
            wr_addr_q.push_back(im_addr);
            wr_cyc_q.push_back(cyc);
        end
        if (core_start === 1'b1) starts <= starts + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic put_gap(input logic [7:0] b);
        put_byte(b);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        int base;
        int st0;

        repeat (3) @(negedge clk);
        chk("rst_hold", 32'(cores_hold), 32'd1);
        chk("rst_we", 32'(im_write_en), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_addr", 32'(im_addr), 32'd0);
        chk("rst_data", 32'(im_input_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back two-word load
        base = wr_data_q.size();
        st0  = starts;
        put_byte(8'h00);
        put_byte(8'h02);
        put_byte(8'h12);
        put_byte(8'h34);
        chk("t1_we0", 32'(im_write_en), 32'd1);
        chk("t1_words0", 32'(words_loaded), 32'd1);
        put_byte(8'hAB);
        put_byte(8'hCD);
        chk("t1_we1", 32'(im_write_en), 32'd1);
        chk("t1_data1", 32'(im_input_data), 32'hABCD);
        chk("t1_addr1", 32'(im_addr), 32'd1);
        chk("t1_done_early", 32'(load_done), 32'd0);
        chk("t1_hold_early", 32'(cores_hold), 32'd1);
        @(negedge clk);
        chk("t1_we_off", 32'(im_write_en), 32'd0);
        chk("t1_start", 32'(core_start), 32'd1);
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_hold", 32'(cores_hold), 32'd0);
        chk("t1_data_hold", 32'(im_input_data), 32'hABCD);
        @(negedge clk);
        chk("t1_start_once", 32'(core_start), 32'd0);
        chk("t1_words", 32'(words_loaded), 32'd2);
        chk("t1_nwr", 32'(wr_data_q.size() - base), 32'd2);
        chk("t1_w0", 32'(wr_data_q[base]), 32'h1234);
        chk("t1_a0", 32'(wr_addr_q[base]), 32'd0);
        chk("t1_w1", 32'(wr_data_q[base+1]), 32'hABCD);
        chk("t1_a1", 32'(wr_addr_q[base+1]), 32'd1);
        chk("t1_spacing", 32'(wr_cyc_q[base+1] - wr_cyc_q[base]), 32'd2);
        chk("t1_nstart", 32'(starts - st0), 32'd1);

        // Same stream with 3 idle cycles between bytes
        do_reload();
        chk("t2_rl_done", 32'(load_done), 32'd0);
        chk("t2_rl_hold", 32'(cores_hold), 32'd1);
        chk("t2_rl_words", 32'(words_loaded), 32'd0);
        base = wr_data_q.size();
        st0  = starts;
        put_gap(8'h00);
        put_gap(8'h02);
        put_gap(8'h12);
        put_gap(8'h34);
        put_gap(8'hAB);
        put_gap(8'hCD);
        chk("t2_nwr", 32'(wr_data_q.size() - base), 32'd2);
        chk("t2_w0", 32'(wr_data_q[base]), 32'h1234);
        chk("t2_a0", 32'(wr_addr_q[base]), 32'd0);
        chk("t2_w1", 32'(wr_data_q[base+1]), 32'hABCD);
        chk("t2_a1", 32'(wr_addr_q[base+1]), 32'd1);
        chk("t2_done", 32'(load_done), 32'd1);
        chk("t2_hold", 32'(cores_hold), 32'd0);
        chk("t2_nstart", 32'(starts - st0), 32'd1);

        // Zero-count header
        do_reload();
        base = wr_data_q.size();
        put_byte(8'h00);
        put_byte(8'h00);
        put_byte(8'h12);
        put_byte(8'h34);
        repeat (2) @(negedge clk);
        chk("t3_err", 32'(load_err), 32'd1);
        chk("t3_hold", 32'(cores_hold), 32'd1);
        chk("t3_done", 32'(load_done), 32'd0);
        chk("t3_nwr", 32'(wr_data_q.size() - base), 32'd0);

        // Count one beyond depth
        do_reload();
        chk("t3b_err_clr", 32'(load_err), 32'd0);
        put_byte(8'h00);
        put_byte(8'h66);
        put_byte(8'h12);
        put_byte(8'h34);
        repeat (2) @(negedge clk);
        chk("t3b_err", 32'(load_err), 32'd1);
        chk("t3b_hold", 32'(cores_hold), 32'd1);
        chk("t3b_nwr", 32'(wr_data_q.size() - base), 32'd0);

        // Full-depth load of 101 words
        do_reload();
        base = wr_data_q.size();
        put_byte(8'h00);
        put_byte(8'h65);
        for (int i = 0; i < 101; i++) begin
            logic [15:0] w;
            w = 16'(i);
            put_byte(w[15:8]);
            put_byte(w[7:0]);
        end
        repeat (2) @(negedge clk);
        chk("t4_nwr", 32'(wr_data_q.size() - base), 32'd101);
        for (int i = 0; i < 101; i++) begin
            chk($sformatf("t4_w%0d", i), 32'(wr_data_q[base+i]), 32'(i));
            chk($sformatf("t4_a%0d", i), 32'(wr_addr_q[base+i]), 32'(i));
        end
        chk("t4_done", 32'(load_done), 32'd1);
        chk("t4_err", 32'(load_err), 32'd0);
        chk("t4_words", 32'(words_loaded), 32'd101);

        // Reload collides with a byte after WORD_HI of word 3
        do_reload();
        base = wr_data_q.size();
        put_byte(8'h00);
        put_byte(8'h05);
        put_byte(8'h11); put_byte(8'h11);
        put_byte(8'h22); put_byte(8'h22);
        put_byte(8'h33); put_byte(8'h33);
        put_byte(8'h44);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        reload   = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b0;
        chk("t5_words", 32'(words_loaded), 32'd0);
        chk("t5_we", 32'(im_write_en), 32'd0);
        chk("t5_hold", 32'(cores_hold), 32'd1);
        chk("t5_done", 32'(load_done), 32'd0);
        chk("t5_nwr_pre", 32'(wr_data_q.size() - base), 32'd3);
        base = wr_data_q.size();
        st0  = starts;
        put_byte(8'h00);
        put_byte(8'h01);
        put_byte(8'hBE);
        put_byte(8'hEF);
        repeat (2) @(negedge clk);
        chk("t5_nwr", 32'(wr_data_q.size() - base), 32'd1);
        chk("t5_w0", 32'(wr_data_q[base]), 32'hBEEF);
        chk("t5_a0", 32'(wr_addr_q[base]), 32'd0);
        chk("t5_nstart", 32'(starts - st0), 32'd1);
        chk("t5_ld", 32'(load_done), 32'd1);

        // Extra bytes after completion are dropped
        base = wr_data_q.size();
        st0  = starts;
        for (int i = 0; i < 5; i++) put_byte(8'hA0 + 8'(i));
        repeat (2) @(negedge clk);
        chk("t6_nwr", 32'(wr_data_q.size() - base), 32'd0);
        chk("t6_done", 32'(load_done), 32'd1);
        chk("t6_nstart", 32'(starts - st0), 32'd0);
        chk("t6_words", 32'(words_loaded), 32'd1);
        chk("t6_hold", 32'(cores_hold), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
